// File: rtl/pwm_fade_ramp.sv
// pwm_fade_ramp: breathing duty-cycle sequencer feeding pwm_dynamic.
// Ramps the duty word up, holds high, ramps down, holds low, then stops or
// loops. Duty only changes on PWM frame boundaries, and every change is
// announced by a one-clock pwm_sync pulse.
// Optional build macro FADE_GAMMA_EN: squares the level for a perceptually
// smoother fade, adding one register stage to pwm_count and pwm_sync.
`timescale 1ns/1ps

module pwm_fade_ramp #(
  parameter int PERIOD      = 255,
  parameter int HOLD_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [7:0] step,
  output logic [7:0] pwm_count,
  output logic       pwm_sync,
  output logic       busy,
  output logic       cycle_done
);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } state_t;

  // A hold length of zero frames would never exit, so it is promoted to one.
  localparam int          HOLD_EFF   = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
  localparam logic [15:0] FRAME_LAST = 16'(PERIOD - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_EFF - 1);

  state_t      r_state;
  logic [15:0] r_frameCnt;
  logic [15:0] r_holdCnt;
  logic [7:0]  r_level;
  logic        r_sync;
  logic        r_busy;
  logic        r_cycleDone;

  logic        w_tick;
  logic [7:0]  w_stepEff;
  logic [8:0]  w_upSum;
  logic [7:0]  w_upLevel;
  logic [7:0]  w_downLevel;

  // Frame boundary: last clock of the current PWM frame while sequencing.
  assign w_tick = (r_state != IDLE) && (r_frameCnt == FRAME_LAST);

  // A zero step would stall the ramp forever, so it behaves as one.
  assign w_stepEff = (step == 8'd0) ? 8'd1 : step;

  // Ramp-up uses a 9-bit sum so overflow saturates cleanly at full scale.
  assign w_upSum   = {1'b0, r_level} + {1'b0, w_stepEff};
  assign w_upLevel = w_upSum[8] ? 8'hFF : w_upSum[7:0];

  // Ramp-down floors at zero instead of wrapping on borrow.
  assign w_downLevel = (r_level > w_stepEff) ? (r_level - w_stepEff) : 8'd0;

  // Sequencer: frame counter, hold counter, duty level and registered strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_frameCnt  <= 16'd0;
      r_holdCnt   <= 16'd0;
      r_level     <= 8'd0;
      r_sync      <= 1'b0;
      r_busy      <= 1'b0;
      r_cycleDone <= 1'b0;
    end else begin
      r_sync      <= 1'b0;
      r_cycleDone <= 1'b0;
      if (r_state == IDLE) begin
        r_frameCnt <= 16'd0;
        if (start && !stop) begin
          r_state   <= RAMP_UP;
          r_level   <= 8'd0;
          r_holdCnt <= 16'd0;
          r_busy    <= 1'b1;
          r_sync    <= 1'b1;
        end
      end else if (stop) begin
        r_state    <= IDLE;
        r_level    <= 8'd0;
        r_frameCnt <= 16'd0;
        r_holdCnt  <= 16'd0;
        r_sync     <= 1'b1;
        r_busy     <= 1'b0;
      end else begin
        r_frameCnt <= w_tick ? 16'd0 : (r_frameCnt + 16'd1);
        if (w_tick) begin
          r_sync <= 1'b1;
          case (r_state)
            RAMP_UP: begin
              r_level <= w_upLevel;
              if (w_upLevel == 8'hFF) begin
                r_state   <= HOLD_HIGH;
                r_holdCnt <= 16'd0;
              end
            end
            HOLD_HIGH: begin
              if (r_holdCnt == HOLD_LAST) begin
                r_state   <= RAMP_DOWN;
                r_holdCnt <= 16'd0;
              end else begin
                r_holdCnt <= r_holdCnt + 16'd1;
              end
            end
            RAMP_DOWN: begin
              r_level <= w_downLevel;
              if (w_downLevel == 8'd0) begin
                r_state   <= HOLD_LOW;
                r_holdCnt <= 16'd0;
              end
            end
            HOLD_LOW: begin
              if (r_holdCnt == HOLD_LAST) begin
                r_holdCnt <= 16'd0;
                if (loop) begin
                  r_state <= RAMP_UP;
                end else begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_cycleDone <= 1'b1;
                end
              end else begin
                r_holdCnt <= r_holdCnt + 16'd1;
              end
            end
            default: begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef FADE_GAMMA_EN
  logic [7:0] r_gammaCount;
  logic       r_syncDly;

  // Gamma stage: rounded-up square of the level, with the sync delayed to match.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gammaCount <= 8'd0;
      r_syncDly    <= 1'b0;
    end else begin
      r_gammaCount <= 8'((({8'd0, r_level} * {8'd0, r_level}) + 16'd255) >> 8);
      r_syncDly    <= r_sync;
    end
  end

  assign pwm_count = r_gammaCount;
  assign pwm_sync  = r_syncDly;
`else
  assign pwm_count = r_level;
  assign pwm_sync  = r_sync;
`endif

  assign busy       = r_busy;
  assign cycle_done = r_cycleDone;

endmodule

// File: tb/tb_pwm_fade_ramp.sv
// tb_pwm_fade_ramp: randomized self-checking bench for pwm_fade_ramp.
// Expected duty sequences come from a frame-level model of the breathing
// profile (one list entry per frame boundary); outputs are compared every
// clock against that list. Honours FADE_GAMMA_EN when the design is built with it.
`timescale 1ns/1ps

module tb_pwm_fade_ramp;

  localparam int PERIOD = 10;
  localparam int HOLD   = 2;
`ifdef FADE_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       loop;
  logic [7:0] step;
  logic [7:0] pwm_count;
  logic       pwm_sync;
  logic       busy;
  logic       cycle_done;

  int testsRun    = 0;
  int testsFailed = 0;
  int expQ[$];

  always #5 clock = ~clock;

  pwm_fade_ramp #(
    .PERIOD(PERIOD),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .stop(stop),
    .loop(loop),
    .step(step),
    .pwm_count(pwm_count),
    .pwm_sync(pwm_sync),
    .busy(busy),
    .cycle_done(cycle_done)
  );

  // Duty word seen by pwm_dynamic for a given fade level.
  function automatic int shapeCount(input int lvl);
`ifdef FADE_GAMMA_EN
    return (lvl * lvl + 255) / 256;
`else
    return lvl;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Appends one full breathing cycle (levels after each frame boundary,
  // starting from a zero level in the ramp-up phase) to expQ.
  task automatic appendCycle(input int stepVal);
    int s;
    int lvl;
    s   = (stepVal == 0) ? 1 : stepVal;
    lvl = 0;
    do begin
      lvl = (lvl + s > 255) ? 255 : lvl + s;
      expQ.push_back(lvl);
    end while (lvl < 255);
    repeat (HOLD) expQ.push_back(255);
    do begin
      lvl = (lvl < s) ? 0 : lvl - s;
      expQ.push_back(lvl);
    end while (lvl > 0);
    repeat (HOLD) expQ.push_back(0);
  endtask

  // Starts a sequence and checks every clock; abortAt >= 0 raises stop
  // (optionally together with start) after that many clocks.
  task automatic applyStimulus(input logic [7:0] stepVal, input logic loopVal,
                               input int abortAt, input logic abortWithStart);
    int n;
    int endE;
    int limit;
    int k;
    int syncExp;
    int countExp;
    int busyExp;
    int doneExp;
    expQ = {};
    expQ.push_back(0);
    appendCycle(int'(stepVal));
    if (loopVal) begin
      while (expQ.size() * PERIOD < abortAt + 2 * PERIOD) appendCycle(int'(stepVal));
    end
    n     = expQ.size();
    endE  = (n - 1) * PERIOD;
    limit = (abortAt >= 0) ? abortAt : endE + LAT + 3;

    @(negedge clock);
    step  = stepVal;
    loop  = loopVal;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;

    for (int e = 0; e < limit; e++) begin
      @(negedge clock);
      if (e < LAT) begin
        syncExp  = 0;
        countExp = shapeCount(0);
      end else begin
        k        = (e - LAT) / PERIOD;
        syncExp  = (((e - LAT) % PERIOD) == 0 && k < n) ? 1 : 0;
        if (k > n - 1) k = n - 1;
        countExp = shapeCount(expQ[k]);
      end
      busyExp = loopVal ? 1 : ((e < endE) ? 1 : 0);
      doneExp = (!loopVal && e == endE) ? 1 : 0;
      checkOutput("pwm_sync", 32'(pwm_sync), syncExp);
      checkOutput("pwm_count", 32'(pwm_count), countExp);
      checkOutput("busy", 32'(busy), busyExp);
      checkOutput("cycle_done", 32'(cycle_done), doneExp);
    end

    if (abortAt >= 0) begin
      stop  = 1'b1;
      start = abortWithStart;
      @(posedge clock);
      #1;
      stop  = 1'b0;
      start = 1'b0;
      for (int j = 0; j < 6; j++) begin
        @(negedge clock);
        if (j >= LAT) begin
          checkOutput("abort_sync", 32'(pwm_sync), (j == LAT) ? 1 : 0);
          checkOutput("abort_count", 32'(pwm_count), 0);
        end
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(cycle_done), 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    step  = 8'd0;

    #12;
    checkOutput("reset_count", 32'(pwm_count), 0);
    checkOutput("reset_sync", 32'(pwm_sync), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(cycle_done), 0);
    @(negedge clock);
    reset = 1'b0;

    // stop while idle must not produce a sync pulse or leave IDLE
    stop = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("idle_stop_sync", 32'(pwm_sync), 0);
      checkOutput("idle_stop_busy", 32'(busy), 0);
    end
    stop = 1'b0;

    // reference one-shot with step 64
    applyStimulus(8'd64, 1'b0, -1, 1'b0);

    // random one-shot sequences
    repeat (4) applyStimulus(8'($urandom_range(2, 255)), 1'b0, -1, 1'b0);

    // zero step behaves as a step of one
    applyStimulus(8'd0, 1'b0, -1, 1'b0);

    // looping with saturation and floor, then aborted
    applyStimulus(8'd200, 1'b1, 200, 1'b0);
    applyStimulus(8'($urandom_range(20, 255)), 1'b1, int'($urandom_range(50, 300)), 1'b0);

    // stop and start together in HOLD_HIGH: stop wins, start ignored
    applyStimulus(8'd128, 1'b0, 25, 1'b1);

    // asynchronous reset in the middle of the ramp at level 128
    @(negedge clock);
    step  = 8'd64;
    loop  = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (25) @(negedge clock);
    checkOutput("pre_reset_count", 32'(pwm_count), shapeCount(128));
    checkOutput("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_count", 32'(pwm_count), 0);
    checkOutput("async_reset_busy", 32'(busy), 0);
    checkOutput("async_reset_sync", 32'(pwm_sync), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      checkOutput("post_reset_sync", 32'(pwm_sync), 0);
      checkOutput("post_reset_busy", 32'(busy), 0);
      checkOutput("post_reset_count", 32'(pwm_count), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ramp.md
Name: pwm_fade_ramp

Overview:
- Upstream duty-cycle sequencer for pwm_dynamic: generates the 8-bit pwm_count word and the frame-restart pulse that drives pwm_dynamic's enable input.
- Produces a "breathing" profile: ramp up, hold high, ramp down, hold low, then stop or loop.
- Duty changes only at PWM frame boundaries, so pwm_dynamic never sees a mid-period duty change.

Parameters:
- PERIOD, 255, clocks per PWM frame; must match pwm_dynamic period (2^8 - 1); legal 2..65535.
- HOLD_FRAMES, 4, frames spent in each hold state; 0 is treated as 1.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins a sequence from IDLE.
- stop  input  1  synchronous abort; priority over start.
- loop  input  1  1 = repeat the sequence continuously; 0 = one shot.
- step  input  8  duty increment/decrement per frame; 0 is treated as 1.
- pwm_count  output  8  duty word to pwm_dynamic.
- pwm_sync  output  1  one-clock frame-restart pulse to pwm_dynamic enable.
- busy  output  1  high in any state except IDLE.
- cycle_done  output  1  one-clock pulse when a one-shot sequence ends.

Behaviour:
- Reset (async, active-high): state=IDLE; level=0; frame_cnt=0; hold_cnt=0; pwm_count=0; pwm_sync=0; busy=0; cycle_done=0.
- All outputs are registered. pwm_count and its pwm_sync pulse update on the same edge.
- frame_cnt is 16-bit and counts 0..PERIOD-1 in non-IDLE states. It is held at 0 in IDLE.
- tick is an internal signal, asserted when frame_cnt==PERIOD-1. frame_cnt wraps to 0 on the next edge.
- pwm_sync pulses:
  - one clock after every tick while busy;
  - on the edge that leaves IDLE via start;
  - on the edge that takes a stop abort.
- States: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
- IDLE: start=1 & stop=0 → RAMP_UP next edge; level=0, pwm_count=0, busy=1, pwm_sync=1.
- RAMP_UP, on tick:
  - level = min(level+step, 255), computed as a 9-bit sum then saturated.
  - If the new level==255 → HOLD_HIGH, hold_cnt=0.
- HOLD_HIGH, on tick: hold_cnt++. When hold_cnt reaches HOLD_FRAMES-1 on a tick → RAMP_DOWN. Level is unchanged.
- RAMP_DOWN, on tick:
  - level = max(level-step, 0), borrow-safe.
  - If the new level==0 → HOLD_LOW, hold_cnt=0.
- HOLD_LOW, after HOLD_FRAMES ticks:
  - loop=1 → RAMP_UP.
  - loop=0 → IDLE, busy=0 on the same edge, cycle_done=1 for one clock.
- pwm_count = level (see optional feature).
- stop=1 in any non-IDLE state → IDLE next edge; level=0, pwm_count=0, pwm_sync=1, busy=0, cycle_done=0. stop in IDLE has no effect.
- start while busy: ignored. Sampling: step and loop are sampled on each tick (step) or at HOLD_LOW exit (loop).
- Mid-operation reset: all state is cleared immediately. There is no pwm_sync pulse on reset release.

Optional Feature:
- Macro: FADE_GAMMA_EN.
- Defined:
  - pwm_count = (level*level + 255) >> 8, a 16-bit product registered one stage.
  - pwm_count and pwm_sync are both delayed one clock so they stay aligned.
  - Endpoints: level 0 → 0, 128 → 64, 255 → 255.
- Undefined: pwm_count = level, no extra latency.

Test Plan (PERIOD=10, HOLD_FRAMES=2):
- Reset asserted mid-RAMP_UP with level=128 → within the same clock pwm_count=0, busy=0, state IDLE; after release nothing changes until start.
- start=1 for 1 clock, step=64, loop=0 → pwm_sync at the start edge, then every 10 clocks; pwm_count sequence 0,64,128,192,255,255,255,191,127,63,0,0,0; then cycle_done pulse, busy=0.
- step=0 → level increases by 1 per frame; reaches 255 after 255 frames.
- step=200, loop=1 → 0,200,255 (saturated), hold 2 frames, 55,0 (floor), hold 2 frames, then 200 again with no IDLE visit and busy constantly 1.
- stop and start asserted together in HOLD_HIGH → next edge IDLE, pwm_count=0, single pwm_sync pulse; start is ignored.
- FADE_GAMMA_EN defined, step=128 → pwm_count 0,64,255 on successive frames, each one clock later than the no-macro build relative to tick.
